clk_mux_n: RTL
==============

# clk_mux_n

- Parametrised glitch-free clock multiplexer: selects one of NCLK asynchronous clocks onto o_clk with break-before-make switching.
- i_clk0 is both input channel 0 (boot clock) and the control domain for the select handshake and the switch FSM.
- A per-switch timeout lets the block leave a dead old or new clock without hanging the control path.
- Sits at the root of a clock tree, ahead of the existing gck cells.

## Interface
- NCLK, 4, number of input clocks, ≥2
- SYNC_STAGES, 2, synchroniser depth in every crossing, ≥2
- TIMEOUT, 1023, i_clk0 cycles allowed per handshake phase; 0 disables timeout
- i_clk0  in  1  channel-0 clock and control-domain clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_clkx  in  [NCLK-1:1]  channel 1..NCLK-1 clocks
- i_sel_vld  in  1  select request strobe (i_clk0)
- i_sel  in  SELW  requested channel, SELW = $clog2(NCLK)
- o_clk  out  1  muxed clock
- o_busy  out  1  switch in progress; requests ignored while high
- o_done  out  1  one-cycle pulse: switch (or no-op) complete
- o_cur  out  SELW  channel currently owning o_clk
- o_fault  out  1  one-cycle pulse: timeout or invalid index
- o_fault_code  out  2  valid with o_fault: 1 drop timeout, 2 raise timeout, 3 bad index

## Operation
- Per channel k: request bit req[k] (i_clk0 domain) → SYNC_STAGES flops clocked by clock k, reset to 0 → en[k] → gck enable. en[k] → SYNC_STAGES flops in i_clk0 → ack[k]. Channel 0 uses the same pipeline depth for uniform timing.
- o_clk = OR over k of gck(clock k, en[k]). At most one en[k] high outside timeout recovery.
- FSM states:
  - RAISE: req[tgt]=1; wait ack[tgt]=1 → IDLE; o_cur=tgt; o_done.
  - IDLE: o_busy=0. Accept i_sel_vld:
    - i_sel ≥ NCLK → o_fault, code 3, stay IDLE.
    - i_sel = o_cur → o_done next cycle, no toggling.
    - Otherwise latch tgt=i_sel → DROP.
  - DROP: req[o_cur]=0; wait ack[o_cur]=0 → RAISE.
- Timeout: counter cleared on entering DROP or RAISE and incremented each i_clk0 cycle. Reaching TIMEOUT forces the transition with o_fault:
  - Code 1 in DROP: old clock presumed dead; its en falls on its next SYNC_STAGES edges if it restarts.
  - Code 2 in RAISE: o_cur=tgt still updates and o_done pulses; o_clk stays low.
- Reset: all req/en/ack = 0, tgt=0, o_cur=0, state RAISE. Channel 0 comes up automatically; o_busy=1 until then.
- i_sel_vld while o_busy=1: dropped, no fault.
- Reset mid-switch: all enables clear asynchronously; o_clk low; sequence restarts at boot.

## Timing
- Reset values: o_clk 0, o_busy 1, o_done 0, o_cur 0, o_fault 0, o_fault_code 0.
- Boot: ack[0] rises 2·SYNC_STAGES i_clk0 edges after reset release; o_done at the next edge.
- Accept edge E → DROP at E+1.
- Old en falls after SYNC_STAGES old-clock edges; ack falls ≤SYNC_STAGES+1 i_clk0 edges later. Raise is symmetric.
- Gap with o_clk low between last old pulse and first new pulse: ≥1 full period of each clock. No pulse shorter than the narrower input half-period.
- Timeout counter width $clog2(TIMEOUT+1); saturates, no wrap.
- o_done and o_fault are single-cycle, registered outputs.

## Structure
- Package clk_mux_n_pkg: FSM state enum (RAISE, IDLE, DROP), fault code constants, SELW function.
- Sub-module clk_mux_sync (SYNC_STAGES-deep, async-reset synchroniser), instantiated 2·NCLK times.
- Existing gck instantiated NCLK times via generate loop.

## Test plan
- Reset release, NCLK=4, clk0 10 ns → o_busy falls and o_done pulses at edge 5; o_cur=0; o_clk tracks clk0.
- Select 2 (clk2 = 7 ns) → o_busy 1; clk0 gated before clk2 starts; gap ≥1 period each; no glitch (pulse-width checker); o_cur=2; o_done.
- Select 2 while o_cur=2 → o_done next cycle; no enable toggles.
- i_sel=5 (NCLK=4, SELW=2 wraps; use NCLK=5, i_sel=6) → o_fault, code 3; o_cur unchanged.
- clk3 stopped, select 3, TIMEOUT=16 → o_fault code 2 at RAISE+16; o_cur=3; o_clk low; then select 0 recovers clk0.
- Assert i_rstn low mid-DROP → o_clk low immediately; after release, boot to channel 0 as in scenario 1.

Source files
------------

// File: rtl/clk_mux_n_pkg.sv
// clk_mux_n_pkg: shared FSM states, fault codes and select-width helper for clk_mux_n
package clk_mux_n_pkg;
    typedef enum logic [1:0] {RAISE, IDLE, DROP} state_t;
    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_DROP = 2'd1;
    localparam logic [1:0] FC_RAISE = 2'd2;
    localparam logic [1:0] FC_BAD = 2'd3;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clk_mux_sync.sv
// clk_mux_sync: STAGES-deep async-reset synchroniser
module clk_mux_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] q;
    // shift the asynchronous input through the flop chain
    always_ff @(posedge i_clk or negedge i_rstn)
        if (!i_rstn) q <= '0;
        else q <= {q[STAGES-2:0], i_d};
    assign o_q = q[STAGES-1];
endmodule

// File: rtl/gck.sv
// gck: latch-based clock gate, enable captured while the clock is low
module gck (
    input  logic i_clk,
    input  logic i_en,
    output logic o_gclk
);
    logic en_l;
    // transparent during the low phase so the gated clock never truncates a pulse
    always_latch if (!i_clk) en_l <= i_en;
    assign o_gclk = i_clk & en_l;
endmodule

// File: rtl/clk_mux_n.sv
// clk_mux_n: glitch-free break-before-make mux of NCLK clocks with handshake timeout
module clk_mux_n import clk_mux_n_pkg::*; #(
    parameter int NCLK = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 1023,
    localparam int SELW = sel_w(NCLK)
) (
    input  logic            i_clk0,
    input  logic            i_rstn,
    input  logic [NCLK-1:1] i_clkx,
    input  logic            i_sel_vld,
    input  logic [SELW-1:0] i_sel,
    output logic            o_clk,
    output logic            o_busy,
    output logic            o_done,
    output logic [SELW-1:0] o_cur,
    output logic            o_fault,
    output logic [1:0]      o_fault_code
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t state, state_n;
    logic [SELW-1:0] tgt, tgt_n, cur_n;
    logic [CW-1:0] cnt, cnt_n;
    logic done_n, fault_n, timed_out;
    logic [1:0] code_n;
    logic [NCLK-1:0] clks, req, en, ack, gclk;

    assign clks = {i_clkx, i_clk0};
    assign timed_out = (TIMEOUT != 0) && (cnt == TLAST);

    // only the owning (IDLE) or incoming (RAISE) channel is requested; DROP requests none
    always_comb begin
        req = '0;
        if (state != DROP) req[(state == RAISE) ? tgt : o_cur] = i_rstn;
    end

    // switch sequencing: accept, break old clock, make new clock, with per-phase timeout
    always_comb begin
        state_n = state;
        tgt_n = tgt;
        cur_n = o_cur;
        done_n = 1'b0;
        fault_n = 1'b0;
        code_n = FC_NONE;
        cnt_n = (cnt == TMAX) ? cnt : cnt + 1'b1;
        unique case (state)
            IDLE: if (i_sel_vld) begin
                if (int'(i_sel) >= NCLK) begin
                    fault_n = 1'b1;
                    code_n = FC_BAD;
                end else if (i_sel == o_cur) begin
                    done_n = 1'b1;
                end else begin
                    tgt_n = i_sel;
                    state_n = DROP;
                    cnt_n = '0;
                end
            end
            DROP: if (!ack[o_cur] || timed_out) begin
                state_n = RAISE;
                cnt_n = '0;
                fault_n = ack[o_cur];
                code_n = ack[o_cur] ? FC_DROP : FC_NONE;
            end
            RAISE: if (ack[tgt] || timed_out) begin
                state_n = IDLE;
                cur_n = tgt;
                done_n = 1'b1;
                fault_n = !ack[tgt];
                code_n = ack[tgt] ? FC_NONE : FC_RAISE;
            end
            default: state_n = RAISE;
        endcase
    end

    // control-domain state and registered status outputs
    always_ff @(posedge i_clk0 or negedge i_rstn)
        if (!i_rstn) begin
            state <= RAISE;
            tgt <= '0;
            o_cur <= '0;
            cnt <= '0;
            o_busy <= 1'b1;
            o_done <= 1'b0;
            o_fault <= 1'b0;
            o_fault_code <= FC_NONE;
        end else begin
            state <= state_n;
            tgt <= tgt_n;
            o_cur <= cur_n;
            cnt <= cnt_n;
            o_busy <= (state_n != IDLE);
            o_done <= done_n;
            o_fault <= fault_n;
            o_fault_code <= code_n;
        end

    for (genvar k = 0; k < NCLK; k++) begin : g_ch
        clk_mux_sync #(.STAGES(SYNC_STAGES)) u_en (
            .i_clk(clks[k]), .i_rstn(i_rstn), .i_d(req[k]), .o_q(en[k])
        );
        clk_mux_sync #(.STAGES(SYNC_STAGES)) u_ack (
            .i_clk(i_clk0), .i_rstn(i_rstn), .i_d(en[k]), .o_q(ack[k])
        );
        gck u_gck (.i_clk(clks[k]), .i_en(en[k]), .o_gclk(gclk[k]));
    end

    // reset forces the output low at once, even mid-pulse
    assign o_clk = i_rstn & (|gclk);
endmodule
